// File: rtl/seq_mult_16_pkg.sv
// Shared definitions for the sequential 16x16 shift-and-add multiplier.
// Holds the FSM state encoding and the fixed iteration/width constants.
package seq_mult_16_pkg;

    localparam int W     = 16;
    localparam int PW    = 32;
    localparam int ITERS = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_16_cla.sv
// 16-bit two-level carry-lookahead adder built from four 4-bit lookahead groups.
// BP/BG are the block propagate/generate terms for cascading into a wider adder.
module CLA_16_bit_lookahead (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout,
    output logic        BP,
    output logic        BG
);

    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;

    assign p = a ^ b;
    assign g = a & b;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_group
            localparam int B = 4 * gi;

            assign gp[gi] = &p[B +: 4];
            assign gg[gi] = g[B+3]
                          | (p[B+3] & g[B+2])
                          | (p[B+3] & p[B+2] & g[B+1])
                          | (p[B+3] & p[B+2] & p[B+1] & g[B]);

            // Carries inside the group depend only on the group carry-in.
            assign c[B]   = gc[gi];
            assign c[B+1] = g[B] | (p[B] & gc[gi]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & gc[gi]);
        end
    endgenerate

    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    assign s    = p ^ c;
    assign cout = gc[4];
    assign BP   = &gp;
    assign BG   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0]);

endmodule

// File: rtl/seq_mult_16.sv
// Sequential unsigned 16x16->32 shift-and-add multiplier, one partial product per
// cycle through the lookahead adder; 16 iterations from start to a one-cycle done.
module seq_mult_16
    import seq_mult_16_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          busy,
    output logic          done,
    output logic [PW-1:0] product
);

    state_t             state_reg;
    state_t             state_next;
    logic [W-1:0]       m_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       q_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [PW-1:0]      product_reg;

    logic               load;
    logic               step;
    logic               last;
    logic [W-1:0]       addend;
    logic [W-1:0]       sum;
    logic               cout;
    logic [PW-1:0]      shifted;
    logic               unused_bp;
    logic               unused_bg;

    assign addend  = q_reg[0] ? m_reg : '0;
    assign last    = (cnt_reg == CNT_W'(ITERS - 1));
    // Carry-out becomes the MSB of A, so the 33-bit shift keeps the product exact.
    assign shifted = {cout, sum, q_reg[W-1:1]};

    CLA_16_bit_lookahead u_cla (
        .a    (a_reg),
        .b    (addend),
        .cin  (1'b0),
        .s    (sum),
        .cout (cout),
        .BP   (unused_bp),
        .BG   (unused_bg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg       <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else if (load) begin
            m_reg   <= a;
            q_reg   <= b;
            a_reg   <= '0;
            cnt_reg <= '0;
        end else if (step) begin
            {a_reg, q_reg} <= shifted;
            cnt_reg        <= cnt_reg + CNT_W'(1);
            if (last) begin
                product_reg <= shifted;
            end
        end
    end

    assign busy    = (state_reg == RUN);
    assign done    = (state_reg == DONE);
    assign product = product_reg;

endmodule
